// File: rtl/sync_merge_n.sv
// N-way four-phase request/acknowledge merge for a clocked island.
// Requests and the merged acknowledge are synchronised, then arbitrated one handshake at a time.
module sync_merge_n #(
    parameter int unsigned N           = 4,
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MODE        = 0,
    localparam int unsigned GW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    r_in,
    output logic [N-1:0]    a_in,
    input  logic [N*DW-1:0] d_in,
    output logic            r_out,
    input  logic            a_out,
    output logic [DW-1:0]   d_out,
    output logic [GW-1:0]   grant_id,
    output logic            busy
);

    typedef enum logic [1:0] {StIdle, StReq, StAck, StRtz} state_e;

    logic [SYNC_STAGES-1:0][N-1:0] r_sync_q;
    logic [SYNC_STAGES-1:0]        a_sync_q;
    logic [N-1:0]                  rs;
    logic                          a_s;

    state_e          state_q, state_d;
    logic            r_out_q, r_out_d;
    logic [N-1:0]    a_in_q, a_in_d;
    logic [N-1:0]    oh_q, oh_d;
    logic [DW-1:0]   d_out_q, d_out_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic            busy_q, busy_d;
    logic [GW-1:0]   ptr_q, ptr_d;

    int              arb_idx;
    logic [N-1:0]    arb_oh;
    logic [DW-1:0]   arb_data;
    logic [GW-1:0]   arb_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_q <= '0;
            a_sync_q <= '0;
        end else begin
            r_sync_q <= {r_sync_q[SYNC_STAGES-2:0], r_in};
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a_out};
        end
    end

    assign rs  = r_sync_q[SYNC_STAGES-1];
    assign a_s = a_sync_q[SYNC_STAGES-1];

    // Round robin searches pointer+1 .. pointer+N; the smallest offset wins.
    always_comb begin
        arb_idx = 0;
        if (N > 1) begin
            if (MODE == 0) begin
                for (int i = int'(N) - 1; i >= 0; i--) begin
                    if ((rs & (N'(1) << i)) != '0) arb_idx = i;
                end
            end else begin
                for (int k = int'(N); k >= 1; k--) begin
                    if ((rs & (N'(1) << ((int'(ptr_q) + k) % int'(N)))) != '0) begin
                        arb_idx = (int'(ptr_q) + k) % int'(N);
                    end
                end
            end
        end
    end

    assign arb_oh    = N'(1) << arb_idx;
    assign arb_data  = d_in[arb_idx*DW +: DW];
    assign arb_grant = arb_idx[GW-1:0];

    always_comb begin
        state_d = state_q;
        r_out_d = r_out_q;
        a_in_d  = a_in_q;
        oh_d    = oh_q;
        d_out_d = d_out_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if ((rs != '0) && !a_s) begin
                    r_out_d = 1'b1;
                    grant_d = arb_grant;
                    oh_d    = arb_oh;
                    d_out_d = arb_data;
                    busy_d  = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (a_s) begin
                    a_in_d  = oh_q;
                    state_d = StAck;
                end
            end
            StAck: begin
                if ((rs & oh_q) == '0) begin
                    r_out_d = 1'b0;
                    state_d = StRtz;
                end
            end
            StRtz: begin
                if (!a_s) begin
                    a_in_d  = '0;
                    busy_d  = 1'b0;
                    if (MODE == 1) ptr_d = grant_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            r_out_q <= 1'b0;
            a_in_q  <= '0;
            oh_q    <= '0;
            d_out_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= GW'(N - 1);
        end else begin
            state_q <= state_d;
            r_out_q <= r_out_d;
            a_in_q  <= a_in_d;
            oh_q    <= oh_d;
            d_out_q <= d_out_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
        end
    end

    assign r_out    = r_out_q;
    assign a_in     = a_in_q;
    assign d_out    = d_out_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule
